// File: rtl/remote_comm_if.sv
// Host <-> link signal bundle: command strobe, UART pins and response handshake.
interface remote_comm_if;
    logic [15:0] cmd;
    logic        send_cmd;
    logic        cmd_sent;
    logic        TX;
    logic        RX;
    logic        clr_resp_rdy;
    logic [7:0]  resp;
    logic        resp_rdy;

    modport master (
        output cmd, send_cmd, RX, clr_resp_rdy,
        input  cmd_sent, TX, resp, resp_rdy
    );

    modport slave (
        input  cmd, send_cmd, RX, clr_resp_rdy,
        output cmd_sent, TX, resp, resp_rdy
    );
endinterface

// File: rtl/remote_comm.sv
// Host-side command link: sends a 16-bit command as two back-to-back UART frames
// (high byte first) and receives single-byte responses on an independent RX path.
module remote_comm #(
    parameter int BAUD_DIV = 2604
) (
    input  logic         clk,
    input  logic         rst_n,
    remote_comm_if.slave bus
);
    localparam int            CW        = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_HIGH, TX_LOW} tx_state_e;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    tx_state_e     tx_state_q, tx_state_d;
    logic [15:0]   cmd_q, cmd_d;
    logic [9:0]    tx_shift_q, tx_shift_d;
    logic [CW-1:0] tx_baud_q, tx_baud_d;
    logic [3:0]    tx_bit_q, tx_bit_d;
    logic          cmd_sent_q, cmd_sent_d;
    logic          tx_bit_done, tx_frame_done;
    logic          load_hi, load_lo, set_sent, tx_busy;

    assign tx_bit_done   = (tx_baud_q == BAUD_LAST);
    assign tx_frame_done = tx_bit_done && (tx_bit_q == 4'd9);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tx_state_q <= TX_IDLE;
        else        tx_state_q <= tx_state_d;
    end

    always_comb begin
        tx_state_d = tx_state_q;
        case (tx_state_q)
            TX_IDLE: if (bus.send_cmd)  tx_state_d = TX_HIGH;
            TX_HIGH: if (tx_frame_done) tx_state_d = TX_LOW;
            TX_LOW:  if (tx_frame_done) tx_state_d = TX_IDLE;
            default:                    tx_state_d = TX_IDLE;
        endcase
    end

    // Strobes only act in IDLE, so a send_cmd mid-transfer is simply dropped.
    always_comb begin
        load_hi  = 1'b0;
        load_lo  = 1'b0;
        set_sent = 1'b0;
        tx_busy  = 1'b0;
        case (tx_state_q)
            TX_IDLE: load_hi = bus.send_cmd;
            TX_HIGH: begin
                tx_busy = 1'b1;
                load_lo = tx_frame_done;
            end
            TX_LOW: begin
                tx_busy  = 1'b1;
                set_sent = tx_frame_done;
            end
            default: ;
        endcase
    end

    // Frame shifter holds {stop, data, start}; shifting in ones leaves the line idle-high.
    always_comb begin
        cmd_d      = cmd_q;
        tx_shift_d = tx_shift_q;
        tx_baud_d  = tx_baud_q;
        tx_bit_d   = tx_bit_q;
        cmd_sent_d = cmd_sent_q;
        if (load_hi) begin
            cmd_d      = bus.cmd;
            tx_shift_d = {1'b1, bus.cmd[15:8], 1'b0};
            tx_baud_d  = '0;
            tx_bit_d   = '0;
            cmd_sent_d = 1'b0;
        end else if (load_lo) begin
            tx_shift_d = {1'b1, cmd_q[7:0], 1'b0};
            tx_baud_d  = '0;
            tx_bit_d   = '0;
        end else if (set_sent) begin
            tx_shift_d = '1;
            tx_baud_d  = '0;
            tx_bit_d   = '0;
            cmd_sent_d = 1'b1;
        end else if (tx_busy) begin
            if (tx_bit_done) begin
                tx_shift_d = {1'b1, tx_shift_q[9:1]};
                tx_baud_d  = '0;
                tx_bit_d   = tx_bit_q + 4'd1;
            end else begin
                tx_baud_d  = tx_baud_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q      <= '0;
            tx_shift_q <= '1;
            tx_baud_q  <= '0;
            tx_bit_q   <= '0;
            cmd_sent_q <= 1'b0;
        end else begin
            cmd_q      <= cmd_d;
            tx_shift_q <= tx_shift_d;
            tx_baud_q  <= tx_baud_d;
            tx_bit_q   <= tx_bit_d;
            cmd_sent_q <= cmd_sent_d;
        end
    end

    assign bus.TX       = tx_shift_q[0];
    assign bus.cmd_sent = cmd_sent_q;

    rx_state_e     rx_state_q, rx_state_d;
    logic          rx_s1_q, rx_s2_q, rx_prev_q;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic [7:0]    resp_q, resp_d;
    logic          resp_rdy_q, resp_rdy_d;
    logic          rx_fall, rx_half, rx_full;
    logic          rx_start, rx_sample, rx_done, rx_cnt_clr;

    // Two-flop synchroniser plus edge history, all preset to the idle-high line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_s1_q   <= bus.RX;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
        end
    end

    assign rx_fall = rx_prev_q & ~rx_s2_q;
    assign rx_half = (rx_cnt_q == HALF_LAST);
    assign rx_full = (rx_cnt_q == BAUD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_state_q <= RX_IDLE;
        else        rx_state_q <= rx_state_d;
    end

    always_comb begin
        rx_state_d = rx_state_q;
        case (rx_state_q)
            RX_IDLE:  if (rx_fall) rx_state_d = RX_START;
            RX_START: if (rx_half) rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_full && rx_bit_q == 3'd7) rx_state_d = RX_STOP;
            RX_STOP:  if (rx_full) rx_state_d = RX_IDLE;
            default:  rx_state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        rx_start   = 1'b0;
        rx_sample  = 1'b0;
        rx_done    = 1'b0;
        rx_cnt_clr = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_start   = rx_fall;
                rx_cnt_clr = 1'b1;
            end
            RX_START: rx_cnt_clr = rx_half;
            RX_DATA: begin
                rx_sample  = rx_full;
                rx_cnt_clr = rx_full;
            end
            RX_STOP: begin
                rx_done    = rx_full;
                rx_cnt_clr = rx_full;
            end
            default: rx_cnt_clr = 1'b1;
        endcase
    end

    // Frame completion outranks a same-cycle clear so a fresh byte is never lost.
    always_comb begin
        rx_cnt_d   = rx_cnt_clr ? '0 : rx_cnt_q + 1'b1;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        resp_d     = resp_q;
        resp_rdy_d = resp_rdy_q;
        if (rx_start) rx_bit_d = '0;
        if (rx_sample) begin
            rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
            rx_bit_d   = rx_bit_q + 3'd1;
        end
        if (rx_done) begin
            resp_d     = rx_shift_q;
            resp_rdy_d = 1'b1;
        end else if (bus.clr_resp_rdy || rx_start) begin
            resp_rdy_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            resp_q     <= '0;
            resp_rdy_q <= 1'b0;
        end else begin
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            resp_q     <= resp_d;
            resp_rdy_q <= resp_rdy_d;
        end
    end

    assign bus.resp     = resp_q;
    assign bus.resp_rdy = resp_rdy_q;
endmodule
